float_mul_iter_param: RTL and testbench
=======================================

Name: float_mul_iter_param

Overview:
- Parametrised IEEE-754-style floating-point multiplier with a req/ack handshake. It uses an iterative mantissa multiplier and generalises the FP32-only multiply unit to any exponent/mantissa width.
- Adds the behaviour the FP32-only unit lacks: round-to-nearest-even, special-value handling (zero/inf/NaN), flush-to-zero, and exception flags.
- Sits in the shader ALU float path, driven by the issue stage.

Parameters:
- EXP_WIDTH, 8, exponent field width (≥3).
- MAN_WIDTH, 23, stored mantissa width, excluding the hidden bit (≥2).
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration; must divide evenly into MAN_WIDTH+1 or is padded up.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  start request; sampled only in IDLE.
- a  in  1+EXP_WIDTH+MAN_WIDTH  operand A.
- b  in  1+EXP_WIDTH+MAN_WIDTH  operand B.
- busy  out  1  high from the accept edge until ack.
- ack  out  1  one-cycle pulse; out/flags valid.
- out  out  1+EXP_WIDTH+MAN_WIDTH  product; held until the next ack.
- flags  out  4  {invalid, overflow, underflow, inexact}; held with out.

Behaviour:
- Reset (async, rst low): state=IDLE; ack=0, busy=0, out=0, flags=0. Any in-flight operation is discarded, and no ack is issued for it after release.
- States:
  - IDLE –req→ UNPACK
  - UNPACK → MULTIPLY
  - MULTIPLY –iterations done→ NORMALIZE
  - NORMALIZE → ROUND
  - ROUND → PACK
  - PACK → IDLE
- Operand capture: a and b are registered on the accept edge. Later changes to a/b or req are ignored while busy.
- Latency: with N = ceil((MAN_WIDTH+1)/BITS_PER_CYCLE), ack is high in cycle N+5 after the accept edge (accept = cycle 0). For FP32 default, N=12, so ack is at cycle 17.
- ack is a single-cycle pulse. If req is high in the ack cycle, it is not accepted; acceptance only occurs with state=IDLE, which is the cycle after ack at earliest. Back-to-back throughput is one op per N+6 cycles.
- UNPACK:
  - sign = sa^sb.
  - Operand classes: exp=0 is zero (subnormals flushed to zero, no flag); exp=all-ones with man=0 is inf; exp=all-ones with man≠0 is NaN.
  - Hidden bit prepended for normals.
  - Start pulse issued to the sub-multiplier.
- MULTIPLY:
  - Unsigned (MAN_WIDTH+1)² product, 2*(MAN_WIDTH+1) bits.
  - Exponent sum = ea+eb-BIAS, computed signed with EXP_WIDTH+2 bits, where BIAS = 2^(EXP_WIDTH-1)-1.
- NORMALIZE: if product MSB is set, shift right 1 and increment the exponent. Then extract the mantissa, guard bit, and sticky (OR of all lower bits).
- ROUND:
  - RNE: increment when guard & (sticky | lsb).
  - Mantissa carry-out renormalises: mantissa=0, exponent+1.
  - inexact = guard | sticky.
- PACK priority:
  1. NaN in, or inf×zero → canonical qNaN: sign 0, exp all-ones, man = 1 followed by 0s. invalid=1 for inf×zero; no flags for NaN propagation.
  2. inf operand → signed inf, no flags.
  3. zero operand → signed zero, no flags.
  4. Rounded exponent ≥ all-ones → signed inf, overflow=1, inexact=1.
  5. Rounded exponent ≤ 0 → signed zero, underflow=1, inexact=1.
  6. Otherwise normal packing.

Decomposition:
- Package float_mul_pkg holds:
  - the state enum;
  - the operand-class enum {ZERO, NORM, INF, NAN};
  - the flag bit-index localparams;
  - functions for BIAS and iteration count from widths.
- Sub-module mant_mul_iter #(WIDTH, BITS_PER_CYCLE):
  - ports: clk, rst, start, a, b, product, done;
  - shift-add, BITS_PER_CYCLE partial products per cycle;
  - done is a 1-cycle pulse exactly N cycles after start;
  - async active-low reset clears the accumulator and done.

Test Plan:
1. FP32: a=0x3FC00000 (1.5), b=0x40000000 (2.0) → out=0x40400000, flags=0, ack exactly 17 cycles after accept.
2. FP32: a=0xC0000000, b=0x40400000 → out=0xC0C00000. Then a=0x3F800001, b=0x3F800001 → out=0x3F800002, flags=inexact only.
3. FP32 specials:
   - 0x7F7FFFFF×0x40000000 → 0x7F800000, overflow+inexact.
   - 0x7F800000×0x00000000 → 0x7FC00000, invalid.
   - 0x00800000×0x3F000000 → 0x00000000, underflow+inexact.
4. FP16 build (EXP_WIDTH=5, MAN_WIDTH=10, BITS_PER_CYCLE=1):
   - 0x3C00×0x3C00 → 0x3C00 at cycle 16.
   - 0x3E00×0x3E00 (1.5²) → 0x4080.
5. Handshake:
   - req held high continuously → one ack per 18 cycles.
   - a changed while busy → result uses the captured value.
   - busy=1 from the cycle after accept until ack.
6. Reset: drop rst at cycle 6 of an operation → ack/out/flags/busy go to 0 immediately, with no ack after release. A fresh req then completes normally.

Source files
------------

// File: rtl/float_mul_iter_param_pkg.sv
// Shared types and width helpers for the parametrised iterative float multiplier.
package float_mul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MULTIPLY,
    NORMALIZE,
    ROUND,
    PACK
  } state_e;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } op_class_e;

  localparam int unsigned FLAG_W         = 4;
  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_INEXACT   = 0;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  function automatic int unsigned bias_of(input int unsigned exp_width);
    return (32'd1 << (exp_width - 32'd1)) - 32'd1;
  endfunction

  // Iterations needed to retire a width-bit multiplier, padded up to whole steps.
  function automatic int unsigned iters_of(input int unsigned width, input int unsigned bpc);
    return (width + bpc - 32'd1) / bpc;
  endfunction

endpackage

// File: rtl/float_mul_iter_param_if.sv
// Issue-stage request/acknowledge bus for the float multiplier.
interface float_mul_iter_param_if #(
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 23
);
  import float_mul_pkg::*;

  localparam int unsigned FW = 1 + EXP_WIDTH + MAN_WIDTH;

  logic              req;
  logic [FW-1:0]     a;
  logic [FW-1:0]     b;
  logic              busy;
  logic              ack;
  logic [FW-1:0]     out;
  logic [FLAG_W-1:0] flags;

  modport master (output req, a, b, input busy, ack, out, flags);
  modport slave  (input req, a, b, output busy, ack, out, flags);

endinterface

// File: rtl/float_mul_iter_param_mant_mul_iter.sv
// Shift-add unsigned multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
module mant_mul_iter
  import float_mul_pkg::*;
#(
  parameter int unsigned WIDTH          = 24,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int unsigned N    = iters_of(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned PADW = N * BITS_PER_CYCLE;
  localparam int unsigned AW   = 2 * WIDTH;
  localparam int unsigned CW   = $clog2(N + 1);

  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   mcand_q, mcand_d;
  logic [PADW-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [AW-1:0]   pp;

  // Accumulation is modulo 2^AW; the true product always fits, so bits lost off the top are zero.
  always_comb begin
    pp = '0;
    for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
      if (mplier_q[j]) pp = pp + (mcand_q << j);
    end
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = AW'(a);
      mplier_d = PADW'(b);
      cnt_d    = CW'(N);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + pp;
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
      cnt_d    = cnt_q - CW'(1);
      done_d   = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign product = acc_q;
  assign done    = done_q;

endmodule

// File: rtl/float_mul_iter_param.sv
// Parametrised float multiplier: RNE rounding, zero/inf/NaN handling, flush-to-zero, flags.
module float_mul_iter_param
  import float_mul_pkg::*;
#(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MAN_WIDTH      = 23,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input logic clk,
  input logic rst,
  float_mul_iter_param_if.slave bus
);

  localparam int unsigned FW   = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int unsigned SW   = MAN_WIDTH + 1;
  localparam int unsigned PW   = 2 * SW;
  localparam int unsigned XW   = EXP_WIDTH + 2;
  localparam int unsigned BIAS = bias_of(EXP_WIDTH);
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

  state_e                 state_q, state_d;
  logic [FW-1:0]          a_q, a_d, b_q, b_d;
  logic                   sign_q, sign_d;
  op_class_e              cls_a_q, cls_a_d, cls_b_q, cls_b_d;
  logic [XW-1:0]          exp_q, exp_d;
  logic [MAN_WIDTH-1:0]   man_q, man_d;
  logic                   guard_q, guard_d, sticky_q, sticky_d;
  logic                   inexact_q, inexact_d;
  logic                   busy_q, busy_d, ack_q, ack_d;
  logic [FW-1:0]          out_q, out_d;
  flags_t                 flags_q, flags_d;

  logic [EXP_WIDTH-1:0]   ea, eb;
  logic [MAN_WIDTH-1:0]   ma, mb;
  op_class_e              cls_a, cls_b;
  logic [SW-1:0]          sig_a, sig_b;
  logic                   mul_start, mul_done;
  logic [PW-1:0]          mul_product;
  logic                   round_up, exp_ovf, exp_unf;
  logic [MAN_WIDTH:0]     man_rounded;
  logic                   any_nan, any_inf, any_zero, inf_times_zero;

  function automatic op_class_e classify(input logic [EXP_WIDTH-1:0] e,
                                         input logic [MAN_WIDTH-1:0] m);
    if (e == '0) return ZERO;
    if (e == '1) return (m == '0) ? INF : NAN;
    return NORM;
  endfunction

  assign ea    = a_q[FW-2:MAN_WIDTH];
  assign eb    = b_q[FW-2:MAN_WIDTH];
  assign ma    = a_q[MAN_WIDTH-1:0];
  assign mb    = b_q[MAN_WIDTH-1:0];
  assign cls_a = classify(ea, ma);
  assign cls_b = classify(eb, mb);
  // Subnormals are flushed: their significand enters the multiplier as zero.
  assign sig_a = (cls_a == ZERO) ? '0 : {1'b1, ma};
  assign sig_b = (cls_b == ZERO) ? '0 : {1'b1, mb};
  assign mul_start = (state_q == UNPACK);

  mant_mul_iter #(
    .WIDTH          (SW),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_mant_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (sig_a),
    .b       (sig_b),
    .product (mul_product),
    .done    (mul_done)
  );

  assign round_up    = guard_q & (sticky_q | man_q[0]);
  assign man_rounded = {1'b0, man_q} + (MAN_WIDTH + 1)'(round_up);
  assign exp_ovf     = $signed(exp_q) >= $signed(XW'(EXP_ONES));
  assign exp_unf     = $signed(exp_q) <  $signed(XW'(1));

  assign any_nan        = (cls_a_q == NAN) || (cls_b_q == NAN);
  assign any_inf        = (cls_a_q == INF) || (cls_b_q == INF);
  assign any_zero       = (cls_a_q == ZERO) || (cls_b_q == ZERO);
  assign inf_times_zero = any_inf && any_zero;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    cls_a_d   = cls_a_q;
    cls_b_d   = cls_b_q;
    exp_d     = exp_q;
    man_d     = man_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    inexact_d = inexact_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    out_d     = out_q;
    flags_d   = flags_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          a_d     = bus.a;
          b_d     = bus.b;
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d  = a_q[FW-1] ^ b_q[FW-1];
        cls_a_d = cls_a;
        cls_b_d = cls_b;
        exp_d   = XW'(ea) + XW'(eb) - XW'(BIAS);
        state_d = MULTIPLY;
      end
      MULTIPLY: begin
        if (mul_done) state_d = NORMALIZE;
      end
      NORMALIZE: begin
        // Product lies in [1,4): a set MSB means one extra integer bit to shift out.
        if (mul_product[PW-1]) begin
          man_d    = mul_product[PW-2 -: MAN_WIDTH];
          guard_d  = mul_product[MAN_WIDTH];
          sticky_d = |mul_product[MAN_WIDTH-1:0];
          exp_d    = exp_q + XW'(1);
        end else begin
          man_d    = mul_product[PW-3 -: MAN_WIDTH];
          guard_d  = mul_product[MAN_WIDTH-1];
          sticky_d = |mul_product[MAN_WIDTH-2:0];
        end
        state_d = ROUND;
      end
      ROUND: begin
        man_d     = man_rounded[MAN_WIDTH-1:0];
        exp_d     = exp_q + XW'(man_rounded[MAN_WIDTH]);
        inexact_d = guard_q | sticky_q;
        state_d   = PACK;
      end
      PACK: begin
        flags_d = '0;
        if (any_nan || inf_times_zero) begin
          out_d           = {1'b0, EXP_ONES, 1'b1, {(MAN_WIDTH-1){1'b0}}};
          flags_d.invalid = !any_nan;
        end else if (any_inf) begin
          out_d = {sign_q, EXP_ONES, {MAN_WIDTH{1'b0}}};
        end else if (any_zero) begin
          out_d = {sign_q, {(FW-1){1'b0}}};
        end else if (exp_ovf) begin
          out_d            = {sign_q, EXP_ONES, {MAN_WIDTH{1'b0}}};
          flags_d.overflow = 1'b1;
          flags_d.inexact  = 1'b1;
        end else if (exp_unf) begin
          out_d             = {sign_q, {(FW-1){1'b0}}};
          flags_d.underflow = 1'b1;
          flags_d.inexact   = 1'b1;
        end else begin
          out_d           = {sign_q, exp_q[EXP_WIDTH-1:0], man_q};
          flags_d.inexact = inexact_q;
        end
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      cls_a_q   <= ZERO;
      cls_b_q   <= ZERO;
      exp_q     <= '0;
      man_q     <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      inexact_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      out_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      cls_a_q   <= cls_a_d;
      cls_b_q   <= cls_b_d;
      exp_q     <= exp_d;
      man_q     <= man_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      inexact_q <= inexact_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      out_q     <= out_d;
      flags_q   <= flags_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ack   = ack_q;
  assign bus.out   = out_q;
  assign bus.flags = flags_q;

endmodule

// File: tb/tb_float_mul_iter_param.sv
// Directed bench for the float multiplier: FP32 and FP16 builds side by side.
module tb_float_mul_iter_param;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  float_mul_iter_param_if #(.EXP_WIDTH(8), .MAN_WIDTH(23)) bus32 ();
  float_mul_iter_param_if #(.EXP_WIDTH(5), .MAN_WIDTH(10)) bus16 ();

  float_mul_iter_param #(.EXP_WIDTH(8), .MAN_WIDTH(23), .BITS_PER_CYCLE(2)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  float_mul_iter_param #(.EXP_WIDTH(5), .MAN_WIDTH(10), .BITS_PER_CYCLE(1)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp_v, input string tag);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One operation; optionally swaps operand A two cycles into the operation.
  task automatic run_op(input bit h, input logic [31:0] av, input logic [31:0] bv,
                        input bit late, input logic [31:0] a_late,
                        input logic [31:0] eo, input logic [3:0] ef,
                        input int lat, input string tag);
    int   k;
    logic got;
    logic bsy;
    @(negedge clk);
    if (h) begin
      bus16.req = 1'b1; bus16.a = av[15:0]; bus16.b = bv[15:0];
    end else begin
      bus32.req = 1'b1; bus32.a = av; bus32.b = bv;
    end
    @(posedge clk); #1;
    bus16.req = 1'b0;
    bus32.req = 1'b0;
    got = 1'b0;
    k   = 0;
    while (!got && k < 40) begin
      bsy = h ? bus16.busy : bus32.busy;
      chk(32'(bsy), 32'd1, $sformatf("%s/busy@%0d", tag, k));
      if (late && k == 2) bus32.a = a_late;
      @(posedge clk); #1;
      k++;
      got = h ? bus16.ack : bus32.ack;
    end
    chk(32'(k), 32'(lat), {tag, "/latency"});
    chk(h ? {16'h0, bus16.out} : bus32.out, eo, {tag, "/out"});
    chk(32'(h ? bus16.flags : bus32.flags), 32'(ef), {tag, "/flags"});
  endtask

  initial begin
    int n;
    int acks;
    rst = 1'b0;
    bus32.req = 1'b0; bus32.a = '0; bus32.b = '0;
    bus16.req = 1'b0; bus16.a = '0; bus16.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(32'(bus32.ack),   32'd0, "rst32/ack");
    chk(32'(bus32.busy),  32'd0, "rst32/busy");
    chk(bus32.out,        32'd0, "rst32/out");
    chk(32'(bus32.flags), 32'd0, "rst32/flags");
    chk(32'(bus16.ack),   32'd0, "rst16/ack");
    chk(32'(bus16.busy),  32'd0, "rst16/busy");
    chk(32'(bus16.out),   32'd0, "rst16/out");
    chk(32'(bus16.flags), 32'd0, "rst16/flags");
    @(negedge clk);
    rst = 1'b1;

    // FP32 normals and rounding
    run_op(1'b0, 32'h3FC00000, 32'h40000000, 1'b0, 32'h0, 32'h40400000, 4'b0000, 17, "mul_1p5x2");
    run_op(1'b0, 32'hC0000000, 32'h40400000, 1'b0, 32'h0, 32'hC0C00000, 4'b0000, 17, "mul_m2x3");
    run_op(1'b0, 32'h3F800001, 32'h3F800001, 1'b0, 32'h0, 32'h3F800002, 4'b0001, 17, "mul_inexact");

    // FP32 specials
    run_op(1'b0, 32'h7F7FFFFF, 32'h40000000, 1'b0, 32'h0, 32'h7F800000, 4'b0101, 17, "ovf");
    run_op(1'b0, 32'h7F800000, 32'h00000000, 1'b0, 32'h0, 32'h7FC00000, 4'b1000, 17, "inf_x_zero");
    run_op(1'b0, 32'h00800000, 32'h3F000000, 1'b0, 32'h0, 32'h00000000, 4'b0011, 17, "unf");
    run_op(1'b0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h0, 32'h7FC00000, 4'b0000, 17, "nan_in");
    run_op(1'b0, 32'hFF800000, 32'h40000000, 1'b0, 32'h0, 32'hFF800000, 4'b0000, 17, "inf_x_2");

    // FP16 build
    run_op(1'b1, 32'h3C00, 32'h3C00, 1'b0, 32'h0, 32'h3C00, 4'b0000, 16, "h_1x1");
    run_op(1'b1, 32'h3E00, 32'h3E00, 1'b0, 32'h0, 32'h4080, 4'b0000, 16, "h_1p5sq");

    // Operand change while busy must not affect the result
    run_op(1'b0, 32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000, 32'h40400000, 4'b0000, 17, "capture");

    // req held high: one ack every 18 cycles
    @(negedge clk);
    bus32.req = 1'b1; bus32.a = 32'h40000000; bus32.b = 32'h40400000;
    n = 0;
    while (bus32.ack !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(32'(bus32.ack), 32'd1, "held/first_ack");
    for (int r = 0; r < 2; r++) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (bus32.ack !== 1'b1 && n < 40);
      chk(32'(n), 32'd18, $sformatf("held/period%0d", r));
      chk(bus32.out, 32'h40C00000, $sformatf("held/out%0d", r));
    end
    bus32.req = 1'b0;

    // Reset mid-operation
    @(negedge clk);
    bus32.req = 1'b1; bus32.a = 32'h3FC00000; bus32.b = 32'h40000000;
    @(posedge clk); #1;
    bus32.req = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk(32'(bus32.ack),   32'd0, "midrst/ack");
    chk(32'(bus32.busy),  32'd0, "midrst/busy");
    chk(bus32.out,        32'd0, "midrst/out");
    chk(32'(bus32.flags), 32'd0, "midrst/flags");
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus32.ack === 1'b1) acks++;
    end
    chk(32'(acks), 32'd0, "midrst/no_ack");
    run_op(1'b0, 32'h3FC00000, 32'h40000000, 1'b0, 32'h0, 32'h40400000, 4'b0000, 17, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
